// File: rtl/dict_hamming_scheduler.sv
// rtl/dict_hamming_scheduler.sv - round-robin scheduler sharing one serial dict_hamming compressor
// Grants one requester at a time, clears the compressor, streams the block MSB-first,
// waits for done (bounded by TIMEOUT) and returns the result on a valid/ready port.
module dict_hamming_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int CHUNK_SIZE    = 4,
    parameter int CODEBOOK_SIZE = 8,
    parameter int NUM_CHUNKS    = 4,
    parameter int TIMEOUT       = 64,
    localparam int INDEX_BITS   = $clog2(CODEBOOK_SIZE),
    localparam int BLOCK_BITS   = NUM_CHUNKS * CHUNK_SIZE,
    localparam int OUT_BITS     = NUM_CHUNKS * INDEX_BITS,
    localparam int ID_BITS      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*BLOCK_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          comp_rst_n,
    output logic                          comp_data_in,
    output logic                          comp_data_valid,
    input  logic [OUT_BITS-1:0]           comp_output,
    input  logic                          comp_done,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_BITS-1:0]            resp_id,
    output logic [OUT_BITS-1:0]           resp_data,
    output logic                          resp_err,
    output logic                          busy
);

    localparam int BCNT_BITS = $clog2(BLOCK_BITS + 1);
    localparam int TCNT_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [BLOCK_BITS-1:0] shreg;
    logic [BCNT_BITS-1:0]  bit_cnt;
    logic [TCNT_BITS-1:0]  tcnt;
    logic [ID_BITS-1:0]    rr_ptr;
    logic [ID_BITS-1:0]    grant_idx;
    logic                  grant_found;
    logic                  last_bit;
    logic                  timed_out;

    assign last_bit  = (bit_cnt == BCNT_BITS'(BLOCK_BITS - 1));
    assign timed_out = (tcnt == TCNT_BITS'(TIMEOUT - 1));

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_BITS'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs; everything is forced quiet while rst is high
    always_comb begin
        state_next      = state;
        req_ready       = '0;
        comp_rst_n      = 1'b1;
        comp_data_valid = 1'b0;
        comp_data_in    = 1'b0;
        resp_valid      = 1'b0;
        busy            = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = CLEAR;
                end
            end
            CLEAR: begin
                comp_rst_n = 1'b0;
                state_next = SHIFT;
            end
            SHIFT: begin
                comp_data_valid = 1'b1;
                comp_data_in    = shreg[BLOCK_BITS-1];
                if (last_bit) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (comp_done || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            req_ready       = '0;
            comp_rst_n      = 1'b0;
            comp_data_valid = 1'b0;
            comp_data_in    = 1'b0;
            resp_valid      = 1'b0;
            busy            = 1'b0;
        end
    end

    // Datapath: block capture, serialiser, counters, response capture, rr pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            tcnt      <= '0;
            rr_ptr    <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        shreg   <= req_data[grant_idx*BLOCK_BITS +: BLOCK_BITS];
                        resp_id <= grant_idx;
                    end
                end
                CLEAR: begin
                    bit_cnt <= '0;
                    tcnt    <= '0;
                end
                SHIFT: begin
                    shreg   <= {shreg[BLOCK_BITS-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                WAIT: begin
                    // done has priority over a coincident timeout
                    if (comp_done) begin
                        resp_data <= comp_output;
                        resp_err  <= 1'b0;
                    end else if (timed_out) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        rr_ptr <= (resp_id == ID_BITS'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dict_hamming_scheduler.sv
// tb/tb_dict_hamming_scheduler.sv - self-checking bench for dict_hamming_scheduler
module tb_dict_hamming_scheduler;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        comp_rst_n;
    logic        comp_data_in;
    logic        comp_data_valid;
    logic [11:0] comp_output;
    logic        comp_done;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [11:0] resp_data;
    logic        resp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr = 0;

    dict_hamming_scheduler #(
        .NUM_REQ(4), .CHUNK_SIZE(4), .CODEBOOK_SIZE(8), .NUM_CHUNKS(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .comp_rst_n(comp_rst_n), .comp_data_in(comp_data_in), .comp_data_valid(comp_data_valid),
        .comp_output(comp_output), .comp_done(comp_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vmask;
        logic [63:0] bus;
        int          delay;   // WAIT cycle index carrying done; <0 means never
        logic [11:0] outv;
        int          hold;    // cycles of resp_ready=0 before handshake
        int          exp_g;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] vmask);
        for (int k = 0; k < 4; k++) begin
            if (vmask[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic job(input logic [3:0] vmask, input logic [63:0] bus, input int delay,
                       input logic [11:0] outv, input int hold, input int exp_g);
        logic [15:0] blk;
        logic [11:0] exp_data;
        logic        exp_err;
        int          nwait;
        blk = bus[exp_g*16 +: 16];
        if (delay >= 0 && delay < TIMEOUT) begin
            nwait = delay + 1; exp_err = 1'b0; exp_data = outv;
        end else begin
            nwait = TIMEOUT;   exp_err = 1'b1; exp_data = '0;
        end
        @(negedge clk);
        req_valid = vmask; req_data = bus; resp_ready = 1'b0; comp_done = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, 64'(4'(1) << exp_g));
        @(negedge clk);
        req_valid = vmask & ~(4'(1) << exp_g);
        comp_done = 1'($urandom % 2);
        #1;
        chk("clear_rst_n", comp_rst_n, 0);
        chk("clear_ready", req_ready, 0);
        chk("clear_busy", busy, 1);
        chk("clear_dvalid", comp_data_valid, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            comp_done = 1'($urandom % 2);
            comp_output = 12'($urandom);
            #1;
            chk("shift_valid", comp_data_valid, 1);
            chk("shift_bit", comp_data_in, blk[15-k]);
            chk("shift_rst_n", comp_rst_n, 1);
            chk("shift_ready", req_ready, 0);
        end
        for (int w = 0; w < nwait; w++) begin
            @(negedge clk);
            comp_done = (w == delay);
            comp_output = (w == delay) ? outv : 12'($urandom);
            #1;
            chk("wait_rvalid", resp_valid, 0);
            chk("wait_dvalid", comp_data_valid, 0);
        end
        @(negedge clk);
        comp_done = 1'b0; comp_output = 12'($urandom); resp_ready = (hold == 0);
        #1;
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, 64'(exp_g));
        chk("resp_data", resp_data, exp_data);
        chk("resp_err", resp_err, exp_err);
        chk("resp_busy", busy, 1);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            comp_done = 1'($urandom % 2); comp_output = 12'($urandom);
            resp_ready = (h == hold);
            #1;
            chk("bp_valid", resp_valid, 1);
            chk("bp_id", resp_id, 64'(exp_g));
            chk("bp_data", resp_data, exp_data);
            chk("bp_err", resp_err, exp_err);
            chk("bp_ready", req_ready, 0);
        end
        model_ptr = (exp_g + 1) % 4;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'b0001, {48'h0, 16'hA6C1}, 2, 12'h5A3, 0, 0};
        tbl[1]  = '{4'b1000, 64'hF00D_0000_0000_0000, 0, 12'h111, 0, 3};
        tbl[2]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 0, 12'h222, 0, 0};
        tbl[3]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 1, 12'h333, 0, 1};
        tbl[4]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 0, 12'h444, 0, 2};
        tbl[5]  = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 3, 12'h555, 0, 3};
        tbl[6]  = '{4'b0101, 64'hAAAA_5555_FFFF_0001, 0, 12'h666, 0, 0};
        tbl[7]  = '{4'b0101, 64'hAAAA_5555_FFFF_0001, 0, 12'h777, 0, 2};
        tbl[8]  = '{4'b0010, 64'h0000_0000_C3C3_0000, -1, 12'hFFF, 0, 1};
        tbl[9]  = '{4'b0100, 64'h0000_8001_0000_0000, TIMEOUT-1, 12'h9A5, 0, 2};
        tbl[10] = '{4'b1001, 64'h7E7E_0000_0000_0F0F, 4, 12'hBEE, 10, 3};
        tbl[11] = '{4'b1001, 64'h7E7E_0000_0000_0F0F, 0, 12'h0C4, 0, 0};

        rst = 1'b1; req_valid = 4'b1111; req_data = '1; resp_ready = 1'b1;
        comp_done = 1'b1; comp_output = 12'hFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst_ready", req_ready, 0);
            chk("rst_rst_n", comp_rst_n, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rvalid", resp_valid, 0);
            chk("rst_dvalid", comp_data_valid, 0);
            chk("rst_din", comp_data_in, 0);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0; comp_done = 1'b0; resp_ready = 1'b0;
        #1;
        chk("rst_id", resp_id, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_err", resp_err, 0);
        chk("post_rst_n", comp_rst_n, 1);
        chk("post_busy", busy, 0);

        for (int i = 0; i < 12; i++) begin
            job(tbl[i].vmask, tbl[i].bus, tbl[i].delay, tbl[i].outv, tbl[i].hold, tbl[i].exp_g);
        end

        // abort mid-SHIFT with reset
        @(negedge clk);
        req_valid = 4'b0010; req_data = {$urandom, $urandom}; resp_ready = 1'b0;
        #1;
        chk("abort_grant", req_ready, 4'b0010);
        @(negedge clk); req_valid = '0;
        for (int k = 0; k < 8; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_dvalid", comp_data_valid, 0);
        chk("abort_rst_n", comp_rst_n, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk); #1;
        chk("abort_dvalid2", comp_data_valid, 0);
        chk("abort_busy2", busy, 0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("abort_no_resp", resp_valid, 0);
            chk("abort_idle", busy, 0);
        end
        model_ptr = 0;
        job(4'b1010, {$urandom, $urandom}, 1, 12'h321, 0, 1);

        for (int i = 0; i < 12; i++) begin
            logic [3:0]  vm;
            logic [63:0] bus;
            int          r, d, g;
            vm  = 4'($urandom_range(1, 15));
            bus = {$urandom, $urandom};
            r   = $urandom % 8;
            d   = (r < 6) ? r : ((r == 6) ? -1 : TIMEOUT - 1);
            g   = model_grant(vm);
            job(vm, bus, d, 12'($urandom), $urandom % 4, g);
        end

        @(negedge clk); req_valid = '0; #1;
        chk("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
